// File: rtl/i2c_read_burst.sv
// rtl/i2c_read_burst.sv - I2C master: write register pointer, repeated START, burst read.
// Optional macro I2C_CLK_STRETCH_EN: hold SCL quarter Q2 while the slave stretches SCLI low.
module i2c_read_burst #(
  parameter int MAX_BYTES = 4,
  parameter int DIV       = 4
) (
  input  logic                   i_pt_ck,
  input  logic                   i_reset,
  input  logic                   i_go,
  input  logic [6:0]             i_slave_addr,
  input  logic [7:0]             i_reg_addr,
  input  logic [4:0]             i_nbytes,
  input  logic                   i_sdai,
  input  logic                   i_scli,
  output logic                   o_sdao,
  output logic                   o_sclo,
  output logic                   o_busy,
  output logic                   o_end_ok,
  output logic                   o_ack_err,
  output logic [8*MAX_BYTES-1:0] o_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WBYTE, S_WACK, S_RSTART, S_RBYTE, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_div_cnt;
  logic [1:0] r_q;
  logic [2:0] r_bit;
  logic [3:0] r_byte;
  logic [3:0] r_nm1;
  logic [1:0] r_phase;
  logic [7:0] r_shift;
  logic [6:0] r_addr;
  logic [7:0] r_reg;
  logic       r_nack;

  logic       w_bit_state;
  logic       w_timed;
  logic       w_stall;
  logic       w_qend;
  logic [3:0] w_nm1;

  assign w_bit_state = (r_state == S_WBYTE) || (r_state == S_WACK) ||
                       (r_state == S_RBYTE) || (r_state == S_MACK);
  assign w_timed     = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef I2C_CLK_STRETCH_EN
  assign w_stall = w_bit_state && (r_q == 2'd2) && !i_scli;
`else
  assign w_stall = 1'b0 & i_scli & w_bit_state;
`endif

  assign w_qend = w_timed && (r_div_cnt == 8'(DIV - 1)) && !w_stall;

  // Index of the last byte to read, after the 0 -> 1 and MAX_BYTES clamps.
  always_comb begin
    if (i_nbytes == 5'd0)                  w_nm1 = 4'd0;
    else if (i_nbytes > 5'(MAX_BYTES))     w_nm1 = 4'(MAX_BYTES - 1);
    else                                   w_nm1 = 4'(i_nbytes - 5'd1);
  end

  always_ff @(posedge i_pt_ck) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_nm1     <= '0;
      r_phase   <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_reg     <= '0;
      r_nack    <= 1'b0;
      o_sdao    <= 1'b1;
      o_sclo    <= 1'b1;
      o_busy    <= 1'b0;
      o_end_ok  <= 1'b0;
      o_ack_err <= 1'b0;
      o_data    <= '0;
    end else begin
      o_end_ok <= 1'b0;
      if (w_qend) begin
        r_div_cnt <= '0;
        r_q       <= r_q + 2'd1;
      end else if (w_timed && !w_stall) begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_addr    <= i_slave_addr;
            r_reg     <= i_reg_addr;
            r_nm1     <= w_nm1;
            r_shift   <= {i_slave_addr, 1'b0};
            r_phase   <= 2'd0;
            r_bit     <= '0;
            r_byte    <= '0;
            o_busy    <= 1'b1;
            o_ack_err <= 1'b0;
            o_data    <= '0;
            r_state   <= S_START;
          end
        end
        S_START, S_RSTART: begin
          if (w_qend) begin
            if (r_q == 2'd1) o_sdao <= 1'b0;
            if (r_q == 2'd3) begin
              o_sclo  <= 1'b0;
              o_sdao  <= r_shift[7];
              r_bit   <= '0;
              r_state <= S_WBYTE;
            end
          end
        end
        S_WBYTE: begin
          if (w_qend) begin
            if (r_q == 2'd1) o_sclo <= 1'b1;
            if (r_q == 2'd3) begin
              o_sclo <= 1'b0;
              if (r_bit == 3'd7) begin
                o_sdao  <= 1'b1;
                r_state <= S_WACK;
              end else begin
                r_bit   <= r_bit + 3'd1;
                o_sdao  <= r_shift[6];
                r_shift <= {r_shift[6:0], 1'b0};
              end
            end
          end
        end
        S_WACK: begin
          if (w_qend) begin
            if (r_q == 2'd1) o_sclo <= 1'b1;
            if (r_q == 2'd2) r_nack <= i_sdai;
            if (r_q == 2'd3) begin
              o_sclo <= 1'b0;
              r_bit  <= '0;
              if (r_nack) begin
                o_ack_err <= 1'b1;
                o_sdao    <= 1'b0;
                r_state   <= S_STOP;
              end else if (r_phase == 2'd0) begin
                r_phase <= 2'd1;
                r_shift <= r_reg;
                o_sdao  <= r_reg[7];
                r_state <= S_WBYTE;
              end else if (r_phase == 2'd1) begin
                // Repeated START begins with both lines released.
                r_phase <= 2'd2;
                r_shift <= {r_addr, 1'b1};
                o_sclo  <= 1'b1;
                o_sdao  <= 1'b1;
                r_state <= S_RSTART;
              end else begin
                r_byte  <= '0;
                o_sdao  <= 1'b1;
                r_state <= S_RBYTE;
              end
            end
          end
        end
        S_RBYTE: begin
          if (w_qend) begin
            if (r_q == 2'd1) o_sclo <= 1'b1;
            if (r_q == 2'd2) begin
              r_shift <= {r_shift[6:0], i_sdai};
              if (r_bit == 3'd7) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                  if (r_byte == 4'(i)) o_data[8*i +: 8] <= {r_shift[6:0], i_sdai};
                end
              end
            end
            if (r_q == 2'd3) begin
              o_sclo <= 1'b0;
              if (r_bit == 3'd7) begin
                o_sdao  <= (r_byte == r_nm1);
                r_state <= S_MACK;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end
          end
        end
        S_MACK: begin
          if (w_qend) begin
            if (r_q == 2'd1) o_sclo <= 1'b1;
            if (r_q == 2'd3) begin
              o_sclo <= 1'b0;
              if (r_byte == r_nm1) begin
                o_sdao  <= 1'b0;
                r_state <= S_STOP;
              end else begin
                r_byte  <= r_byte + 4'd1;
                r_bit   <= '0;
                o_sdao  <= 1'b1;
                r_state <= S_RBYTE;
              end
            end
          end
        end
        S_STOP: begin
          if (w_qend) begin
            if (r_q == 2'd0) o_sclo <= 1'b1;
            if (r_q == 2'd1) o_sdao <= 1'b1;
            if (r_q == 2'd3) begin
              o_end_ok <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
